// File: rtl/gate_truth_table_checker_if.sv
// Harness-to-checker bundle: stimulus, gate sample and sweep results.
// Latency: wires only, no storage.
// Backpressure: none; start is a level request honoured only when the checker is idle.
//
// Ports (signals):
//   start, abort, s_in                    : into the checker
//   a_out, b_out, busy, done, pass,
//   err_count[2:0], fail_mask[3:0]        : out of the checker
interface gate_truth_table_checker_if;
    logic       start;
    logic       abort;
    logic       s_in;
    logic       a_out;
    logic       b_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_mask;

    // master: the environment driving requests and hosting the gate under test
    modport master (
        output start, abort, s_in,
        input  a_out, b_out, busy, done, pass, err_count, fail_mask
    );

    // slave: the checker itself
    modport slave (
        input  start, abort, s_in,
        output a_out, b_out, busy, done, pass, err_count, fail_mask
    );
endinterface

// File: rtl/gate_truth_table_checker.sv
// Sweeps {a,b} through 00..11, samples a 2-input gate and scores it against EXPECT.
// Latency: 4*SETTLE cycles from the start edge to the done pulse.
// Backpressure: start ignored while busy; abort cancels a sweep and holds partial results.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : slave side of gate_truth_table_checker_if (start/abort/s_in in,
//            a_out/b_out stimulus and busy/done/pass/err_count/fail_mask out)
module gate_truth_table_checker #(
    parameter logic [3:0]  EXPECT = 4'b0100,  // expected s, bit index = {a,b}
    parameter int unsigned SETTLE = 2         // cycles per vector, 1..255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    gate_truth_table_checker_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The start edge counts as the first settle cycle, hence SETTLE-1.
    localparam logic [7:0] CNT_RELOAD = 8'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] mask_q, mask_d;
    logic       mismatch;
    logic [2:0] err_sample;

    always_comb begin
        // Case inequality so an X/Z gate output scores as a mismatch in simulation.
        mismatch   = (bus.s_in !== EXPECT[idx_q]);
        // At most four samples per sweep, so this cannot pass 4.
        err_sample = err_q + {2'b00, mismatch};
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        mask_d  = mask_q;

        if (state_q == IDLE) begin
            if (bus.start) begin
                state_d = RUN;
                idx_d   = 2'd0;
                cnt_d   = CNT_RELOAD;
                pass_d  = 1'b0;
                err_d   = 3'd0;
                mask_d  = 4'd0;
            end
        end else begin
            if (bus.abort) begin
                // Partial err/mask are kept for inspection; no done.
                state_d = IDLE;
                pass_d  = 1'b0;
            end else if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end else begin
                err_d = err_sample;
                if (mismatch) begin
                    mask_d[idx_q] = 1'b1;
                end
                if (idx_q != 2'd3) begin
                    idx_d = idx_q + 2'd1;
                    cnt_d = CNT_RELOAD;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    pass_d  = (err_sample == 3'd0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            mask_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    // Stimulus is the vector index while running and 00 otherwise.
    assign bus.busy      = (state_q == RUN);
    assign bus.a_out     = (state_q == RUN) & idx_q[1];
    assign bus.b_out     = (state_q == RUN) & idx_q[0];
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_mask = mask_q;

endmodule
